// File: rtl/icache_axi_rd_bridge.sv
// I-cache refill responder: one line-read request becomes one 2-beat AXI4 INCR read.
// Optional `ICACHE_BRIDGE_ERR_CHECK_EN` enables the sticky err flag for bad R responses.
module icache_axi_rd_bridge #(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 64,
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_rdy,
  output logic              ret_valid,
  output logic              ret_last,
  output logic [DATA_W-1:0] ret_data,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [3:0]        arid,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic [3:0]        rid,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t state_reg, state_next;
  logic   beat_reg;
  logic   r_fire;

  assign arlen   = 8'd1;
  assign arsize  = 3'd3;
  assign arburst = 2'b01;
  assign arid    = AXI_ID;

  assign r_fire = rvalid && rready;

  always_ff @(posedge clock) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // The beat count, not rlast, decides when the burst is over.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (rd_req)              state_next = ADDR;
      ADDR:    if (arready)             state_next = DATA;
      DATA:    if (r_fire && beat_reg)  state_next = IDLE;
      default:                          state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_rdy  = 1'b0;
    arvalid = 1'b0;
    rready  = 1'b0;
    case (state_reg)
      IDLE:    rd_rdy  = 1'b1;
      ADDR:    arvalid = 1'b1;
      DATA:    rready  = 1'b1;
      default: rd_rdy  = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      araddr    <= '0;
      beat_reg  <= 1'b0;
      ret_valid <= 1'b0;
      ret_last  <= 1'b0;
      ret_data  <= '0;
    end else begin
      if (state_reg == IDLE && rd_req)
        araddr <= {rd_addr[ADDR_W-1:4], 4'b0000};
      if (state_reg == ADDR && arready)
        beat_reg <= 1'b0;
      else if (r_fire)
        beat_reg <= ~beat_reg;
      ret_valid <= r_fire;
      ret_last  <= r_fire && beat_reg;
      if (r_fire)
        ret_data <= rdata;
    end
  end

`ifdef ICACHE_BRIDGE_ERR_CHECK_EN
  logic bad_beat;
  logic unused_addr_bits;

  assign bad_beat = (rresp != 2'b00) || (rid != AXI_ID) ||
                    (rlast && !beat_reg) || (!rlast && beat_reg);
  assign unused_addr_bits = ^rd_addr[3:0];

  always_ff @(posedge clock) begin
    if (reset)                   err <= 1'b0;
    else if (r_fire && bad_beat) err <= 1'b1;
  end
`else
  logic unused_inputs;

  assign unused_inputs = ^{rresp, rid, rlast, rd_addr[3:0]};
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Randomized directed bench for icache_axi_rd_bridge against a transaction-level line-refill model.
module tb_icache_axi_rd_bridge;

`ifdef ICACHE_BRIDGE_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rd_req = 1'b0;
  logic [31:0] rd_addr = '0;
  logic        rd_rdy;
  logic        ret_valid, ret_last;
  logic [63:0] ret_data;
  logic        arvalid, arready = 1'b0;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arid;
  logic        rvalid = 1'b0, rready;
  logic [63:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic [3:0]  rid = '0;
  logic        err;

  int passes = 0;
  int total  = 0;
  bit err_model = 1'b0;

  icache_axi_rd_bridge dut (
    .clock(clock), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid), .err(err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rd_rdy"}, 64'(rd_rdy), 64'd1);
    check({tag, "_arvalid"}, 64'(arvalid), 64'd0);
    check({tag, "_araddr"}, 64'(araddr), 64'd0);
    check({tag, "_rready"}, 64'(rready), 64'd0);
    check({tag, "_ret_valid"}, 64'(ret_valid), 64'd0);
    check({tag, "_ret_last"}, 64'(ret_last), 64'd0);
    check({tag, "_ret_data"}, ret_data, 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
  endtask

  // One full line refill, starting in a cycle where the bridge is idle.
  // Ends in the cycle after the last R handshake (ret_last cycle).
  task automatic refill(input logic [31:0] addr, input logic [63:0] d0, input logic [63:0] d1,
                        input int ar_delay, input int gap, input logic [1:0] resp1,
                        input bit rlast0, input bit busy_req);
    logic [31:0] line_addr;
    logic [63:0] beats[2];
    line_addr = addr & 32'hFFFF_FFF0;
    beats[0] = d0;
    beats[1] = d1;
    check("idle_rd_rdy", 64'(rd_rdy), 64'd1);
    rd_req  = 1'b1;
    rd_addr = addr;
    tick();
    rd_req = 1'b0;
    check("ar_valid", 64'(arvalid), 64'd1);
    check("ar_rd_rdy_low", 64'(rd_rdy), 64'd0);
    check("ar_addr", 64'(araddr), 64'(line_addr));
    check("ar_len_size_burst_id", {51'd0, arlen, arsize, arburst}, {51'd0, 8'd1, 3'd3, 2'b01});
    check("ar_id", 64'(arid), 64'd0);
    for (int i = 0; i < ar_delay; i++) begin
      if (busy_req && i == 0) begin
        rd_req  = 1'b1;
        rd_addr = ~addr;
      end
      tick();
      rd_req = 1'b0;
      check("ar_hold_valid", 64'(arvalid), 64'd1);
      check("ar_hold_addr", 64'(araddr), 64'(line_addr));
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check("data_rready", 64'(rready), 64'd1);
    check("data_arvalid_low", 64'(arvalid), 64'd0);
    for (int b = 0; b < 2; b++) begin
      for (int g = 0; g < gap; g++) begin
        tick();
        check("gap_no_ret", 64'(ret_valid), 64'd0);
        check("gap_rready", 64'(rready), 64'd1);
      end
      rvalid = 1'b1;
      rdata  = beats[b];
      rresp  = (b == 1) ? resp1 : 2'b00;
      rlast  = (b == 1) ? 1'b1 : rlast0;
      rid    = 4'd0;
      tick();
      rvalid = 1'b0;
      rresp  = 2'b00;
      rlast  = 1'b0;
      check("ret_valid", 64'(ret_valid), 64'd1);
      check("ret_data", ret_data, beats[b]);
      check("ret_last", 64'(ret_last), 64'(b == 1));
    end
    if (ERR_EN && (resp1 != 2'b00 || rlast0)) err_model = 1'b1;
    check("end_rd_rdy", 64'(rd_rdy), 64'd1);
    check("end_no_new_ar", 64'(arvalid), 64'd0);
    check("err", 64'(err), 64'(err_model));
    $display("refill addr=%08h line=%08h d0=%016h d1=%016h ar_delay=%0d gap=%0d err=%0b",
             addr, line_addr, d0, d1, ar_delay, gap, err);
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    check_reset_state("reset");

    // Basic refill, fastest timing.
    refill(32'h8000_1238, 64'h1111, 64'h2222, 0, 0, 2'b00, 1'b0, 1'b0);
    tick();
    check("after_last_pulse_clear", 64'(ret_valid), 64'd0);

    // Backpressure and an ignored request while busy.
    refill(32'h4000_00AC, 64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002, 5, 3, 2'b00, 1'b0, 1'b1);
    // Back-to-back: next request issued in the ret_last cycle.
    refill(32'h1234_567F, 64'hA5A5, 64'h5A5A, 1, 1, 2'b00, 1'b0, 1'b0);
    refill(32'h0000_0010, 64'h0F0F, 64'hF0F0, 0, 0, 2'b00, 1'b0, 1'b0);

    // Reset after beat 0.
    rd_req  = 1'b1;
    rd_addr = 32'h7777_7777;
    tick();
    rd_req  = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = 64'h9999;
    tick();
    rvalid = 1'b0;
    check("midburst_beat0", ret_data, 64'h9999);
    reset = 1'b1;
    rvalid = 1'b1;
    rdata  = 64'hBAD0;
    tick();
    reset = 1'b0;
    check_reset_state("midreset");
    tick();
    rvalid = 1'b0;
    check("postreset_no_ret", 64'(ret_valid), 64'd0);
    $display("reset mid-burst addr=77777777");
    refill(32'h2468_ACE0, 64'h1357, 64'h2468, 2, 0, 2'b00, 1'b0, 1'b0);

    // Error response on beat 1, then rlast anomaly on beat 0.
    refill(32'h3000_0008, 64'hE0, 64'hE1, 0, 0, 2'b10, 1'b0, 1'b0);
    refill(32'h3000_0020, 64'hE2, 64'hE3, 0, 1, 2'b00, 1'b0, 1'b0);
    refill(32'h3000_0040, 64'hE4, 64'hE5, 1, 0, 2'b00, 1'b1, 1'b0);
    tick();
    check("err_sticky", 64'(err), 64'(err_model));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    err_model = 1'b0;
    check_reset_state("err_reset");

    // Randomized refills.
    for (int n = 0; n < 20; n++) begin
      refill($urandom, {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 4), $urandom_range(0, 3), 2'b00, 1'b0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/icache_axi_rd_bridge.md
# icache_axi_rd_bridge

Refill responder for the instruction cache: accepts the cache's single-cycle line-read request (rd_req/rd_addr/rd_rdy), issues one AXI4 INCR read burst of two 64-bit beats, and returns the beats on ret_valid/ret_last/ret_data, low half first. It sits between the I-cache miss port and the AXI interconnect. One request is outstanding at a time.

## Interface
- ADDR_W, 32, request/AXI address width
- DATA_W, 64, return/AXI data width (fixed at 64; the line is 2 beats)
- AXI_ID, 0, constant ARID value, 4 bits
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- rd_req  in  1  one-cycle line-read request from the cache
- rd_addr  in  ADDR_W  line address; bits [3:0] ignored
- rd_rdy  out  1  bridge can accept rd_req this cycle
- ret_valid  out  1  return beat valid (one-cycle pulse per beat)
- ret_last  out  1  second (last) beat of the line
- ret_data  out  64  beat data
- arvalid / arready  out / in  1  AXI AR handshake
- araddr  out  ADDR_W  {rd_addr[ADDR_W-1:4], 4'b0}
- arlen  out  8  constant 8'd1
- arsize  out  3  constant 3'd3
- arburst  out  2  constant 2'b01 (INCR)
- arid  out  4  constant AXI_ID
- rvalid / rready  in / out  1  AXI R handshake
- rdata  in  64  R data
- rresp  in  2  R response
- rlast  in  1  R last
- rid  in  4  R id
- err  out  1  sticky protocol/response error (see Configuration)

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: rd_rdy=1, arvalid=0, rready=0. rd_req=1 latches araddr (low 4 bits zeroed) and moves to ADDR.
- ADDR: arvalid=1, araddr stable until arvalid&&arready, then DATA; beat counter cleared.
- DATA: rready=1. On each rvalid&&rready: ret_data<=rdata, ret_valid<=1, ret_last<=(beat==1), beat increments. On the beat==1 handshake, go to IDLE.
- Beat count is authoritative; rlast does not end the burst. Beat 0 maps to line bytes [7:0], beat 1 to [15:8].
- rd_req while rd_rdy=0 is ignored (dropped, not queued).
- ret_valid/ret_last are single-cycle pulses; cleared in every cycle without an R handshake.
- Reset values: state IDLE, rd_rdy=1, arvalid=0, araddr=0, rready=0, ret_valid=0, ret_last=0, ret_data=0, err=0, beat=0.
- Reset mid-burst: abandons the transaction immediately; no partial ret_last is ever emitted after reset.

## Timing
- rd_req at cycle T -> arvalid=1 at T+1; rd_rdy=0 from T+1.
- arvalid held until the arready cycle A; rready=1 from A+1.
- R handshake at cycle t -> ret_valid at t+1 (registered, 1-cycle latency).
- Final handshake at L -> ret_valid=ret_last=1 and rd_rdy=1 at L+1; a new rd_req at L+1 is accepted.
- Minimum request-to-ret_last: 4 cycles (arready at T+1, rvalid at T+2, T+3).
- rvalid stalls are tolerated for arbitrary length; rready stays 1 throughout DATA.

## Configuration
- ICACHE_BRIDGE_ERR_CHECK_EN defined: err is set (sticky until reset) on any DATA handshake with rresp!=2'b00, rid!=AXI_ID, rlast=1 on beat 0, or rlast=0 on beat 1. Data is still forwarded unchanged; the FSM is unaffected.
- Not defined: err is tied 0; rresp, rid, and rlast are ignored.

## Test plan
- Basic refill: rd_req with rd_addr=0x8000_1238, arready=1 immediately, R beats 0x1111 then 0x2222 back-to-back -> araddr=0x8000_1230, arlen=1, arsize=3, arburst=1; ret_data 0x1111 (last=0) then 0x2222 (last=1) on consecutive cycles; rd_rdy=1 on the last-beat cycle.
- Backpressure: arready low for 5 cycles, 3 idle cycles between beats -> araddr stable while arvalid; exactly two ret_valid pulses; rd_req while busy is ignored (no second AR).
- Back-to-back: new rd_req on the ret_last cycle -> accepted; second arvalid on the next cycle with the new address.
- Reset mid-burst: reset after beat 0 -> all outputs at reset values next cycle; no ret_last; a new request completes normally.
- Error check (macro on): beat 1 with rresp=2'b10 -> data forwarded, err=1 and held until reset. Macro off: same stimulus -> err=0.
- rlast anomaly (macro on): rlast=1 on beat 0 -> burst still completes at beat 1 with ret_last there, and err=1.
